// File: rtl/swseq_pkg.sv
// -----------------------------------------------------------------------------
// swseq_pkg
// Shared types and constants for the switch sequencer.
//   state_e   : sequencer state, value doubles as the LED debug phase code
//   PAT_W     : width of the captured switch pattern
//   ROT_STEPS : rotations performed in ROTATE (one full turn of the pattern)
//   rotl1     : rotate a pattern left by one bit, MSB wraps into bit 0
// -----------------------------------------------------------------------------
package swseq_pkg;

  localparam int PAT_W     = 8;
  localparam int ROT_STEPS = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHOW   = 2'd1,
    INVERT = 2'd2,
    ROTATE = 2'd3
  } state_e;

  function automatic logic [PAT_W-1:0] rotl1(input logic [PAT_W-1:0] v);
    return {v[PAT_W-2:0], v[PAT_W-1]};
  endfunction

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Synchronizes the raw active-low push button, filters bounce and emits a
// one-cycle pulse when the filtered level goes from released (1) to
// pressed (0). Release produces no pulse.
//
// Ports:
//   clk      : board clock
//   rst_n    : asynchronous active-low reset
//   i_key_n  : raw push button, active-low, asynchronous, bouncy
//   o_press  : single-cycle pulse on each accepted press
//
// Parameter DB_CYCLES: consecutive cycles the synchronized level must differ
// from the accepted level before the change is taken.
// -----------------------------------------------------------------------------
module key_debounce
  import swseq_pkg::*;
#(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_n,
  output logic o_press
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_db;
  logic [CW-1:0] r_cnt;
  logic          r_press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_db    <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        // Level accepted: flip, and flag a press only on the 1->0 direction.
        r_db    <= ~r_db;
        r_cnt   <= '0;
        r_press <= r_db;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/switch_sequencer.sv
// -----------------------------------------------------------------------------
// switch_sequencer
// Captures the slide switches on a debounced key press and plays a timed
// display sequence into the switch-to-LED datapath:
//   SHOW   : pattern passed through          (HOLD_TICKS ticks)
//   INVERT : pattern with datapath inverting (HOLD_TICKS ticks)
//   ROTATE : pattern rotated left once per tick, eight times
// then back to IDLE. A press in any state recaptures and restarts at SHOW.
//
// Build option: define SWSEQ_LOOP_EN to make ROTATE completion return to SHOW
// (continuous looping until reset or the next press) instead of IDLE.
//
// Ports:
//   clk    : 50 MHz board clock
//   rst_n  : asynchronous active-low reset
//   sw     : raw slide switches, sampled only when a press is taken
//   key_n  : raw push button, active-low
//   a_out  : value to datapath a input (registered)
//   b_out  : datapath select, 1 = pass, 0 = invert (registered)
//   busy   : high whenever the sequencer is not IDLE
//   phase  : current state code for LED debug
// -----------------------------------------------------------------------------
module switch_sequencer
  import swseq_pkg::*;
#(
  parameter int TICK_DIV   = 50000000,
  parameter int DB_CYCLES  = 500000,
  parameter int HOLD_TICKS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PAT_W-1:0] sw,
  input  logic             key_n,
  output logic [PAT_W-1:0] a_out,
  output logic             b_out,
  output logic             busy,
  output logic [1:0]       phase
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [2:0]    ROT_LAST  = 3'(ROT_STEPS - 1);

  state_e           r_state;
  logic [PAT_W-1:0] r_pat;
  logic [TW-1:0]    r_tick_cnt;
  logic [HW-1:0]    r_hold_cnt;
  logic [2:0]       r_rot_cnt;
  logic [PAT_W-1:0] r_a_out;
  logic             r_b_out;

  state_e           w_state_nxt;
  logic [PAT_W-1:0] w_pat_nxt;
  logic [2:0]       w_rot_nxt;
  logic             w_clr;
  logic             w_press;
  logic             w_tick;
  logic             w_hold_done;
  logic [PAT_W-1:0] w_a_nxt;
  logic             w_b_nxt;

  key_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_key_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_key_n (key_n),
    .o_press (w_press)
  );

  assign w_tick      = (r_tick_cnt == TICK_LAST);
  assign w_hold_done = w_tick && (r_hold_cnt == HOLD_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Pattern, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pat      <= '0;
      r_tick_cnt <= '0;
      r_hold_cnt <= '0;
      r_rot_cnt  <= '0;
      r_a_out    <= '0;
      r_b_out    <= 1'b1;
    end else begin
      r_pat     <= w_pat_nxt;
      r_rot_cnt <= w_rot_nxt;
      r_a_out   <= w_a_nxt;
      r_b_out   <= w_b_nxt;
      // Every state change restarts timing so each state gets full ticks.
      if (w_clr) begin
        r_tick_cnt <= '0;
        r_hold_cnt <= '0;
      end else if (w_tick) begin
        r_tick_cnt <= '0;
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end else begin
        r_tick_cnt <= r_tick_cnt + 1'b1;
      end
    end
  end

  // Next-state logic; press outranks any tick-driven move.
  always_comb begin
    w_state_nxt = r_state;
    w_pat_nxt   = r_pat;
    w_rot_nxt   = r_rot_cnt;
    w_clr       = 1'b0;
    if (w_press) begin
      w_state_nxt = SHOW;
      w_pat_nxt   = sw;
      w_rot_nxt   = '0;
      w_clr       = 1'b1;
    end else begin
      unique case (r_state)
        IDLE: begin
        end
        SHOW: begin
          if (w_hold_done) begin
            w_state_nxt = INVERT;
            w_clr       = 1'b1;
          end
        end
        INVERT: begin
          if (w_hold_done) begin
            w_state_nxt = ROTATE;
            w_rot_nxt   = '0;
            w_clr       = 1'b1;
          end
        end
        ROTATE: begin
          if (w_tick) begin
            w_pat_nxt = rotl1(r_pat);
            w_rot_nxt = r_rot_cnt + 1'b1;
            // Eighth rotation brings the pattern back to its captured value.
            if (r_rot_cnt == ROT_LAST) begin
`ifdef SWSEQ_LOOP_EN
              w_state_nxt = SHOW;
`else
              w_state_nxt = IDLE;
`endif
              w_clr = 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // Output decode from the upcoming state so outputs register with it.
  always_comb begin
    w_a_nxt = '0;
    w_b_nxt = 1'b1;
    unique case (w_state_nxt)
      IDLE: begin
        w_a_nxt = '0;
        w_b_nxt = 1'b1;
      end
      SHOW: begin
        w_a_nxt = w_pat_nxt;
        w_b_nxt = 1'b1;
      end
      INVERT: begin
        w_a_nxt = w_pat_nxt;
        w_b_nxt = 1'b0;
      end
      ROTATE: begin
        w_a_nxt = w_pat_nxt;
        w_b_nxt = 1'b1;
      end
      default: begin
        w_a_nxt = '0;
        w_b_nxt = 1'b1;
      end
    endcase
  end

  assign a_out = r_a_out;
  assign b_out = r_b_out;
  assign busy  = (r_state != IDLE);
  assign phase = r_state;

endmodule

// File: tb/tb_switch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_switch_sequencer
// Scoreboard bench for switch_sequencer. A timeline model (cycles since the
// sequence started, captured pattern) predicts the outputs after every clock
// edge; a monitor compares them against the DUT on the falling edge.
// -----------------------------------------------------------------------------
module tb_switch_sequencer;

  localparam int TICK_DIV   = 4;
  localparam int DB_CYCLES  = 3;
  localparam int HOLD_TICKS = 2;

  localparam int SHOW_LEN  = HOLD_TICKS * TICK_DIV;
  localparam int ROT_LEN   = 8 * TICK_DIV;
  localparam int SEQ_LEN   = 2 * SHOW_LEN + ROT_LEN;
  // key_n edge -> press pulse (2 + DB + 1), plus one edge for the FSM to act
  localparam int ENTRY_LAT = 2 + DB_CYCLES + 1 + 1;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sw    = 8'h00;
  logic       key_n = 1'b1;
  logic [7:0] a_out;
  logic       b_out;
  logic       busy;
  logic [1:0] phase;

  typedef struct packed {
    logic [7:0] a;
    logic       b;
    logic       busy;
    logic [1:0] ph;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Timeline model state
  bit         m_active = 1'b0;
  int         m_k      = 0;
  logic [7:0] m_pat    = 8'h00;
  logic [7:0] m_sw     = 8'h00;
  int         m_pend   = 0;

  switch_sequencer #(
    .TICK_DIV   (TICK_DIV),
    .DB_CYCLES  (DB_CYCLES),
    .HOLD_TICKS (HOLD_TICKS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (sw),
    .key_n (key_n),
    .a_out (a_out),
    .b_out (b_out),
    .busy  (busy),
    .phase (phase)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rotl(input logic [7:0] p, input int n);
    int v;
    v = int'(p);
    v = ((v << n) | (v >> (8 - n))) & 255;
    return v[7:0];
  endfunction

  function automatic exp_t model_out();
    int kk;
    if (!m_active) return {8'h00, 1'b1, 1'b0, 2'd0};
`ifdef SWSEQ_LOOP_EN
    kk = m_k % SEQ_LEN;
`else
    kk = m_k;
`endif
    if (kk < SHOW_LEN)          return {m_pat, 1'b1, 1'b1, 2'd1};
    else if (kk < 2 * SHOW_LEN) return {m_pat, 1'b0, 1'b1, 2'd2};
    else return {rotl(m_pat, (kk - 2 * SHOW_LEN) / TICK_DIV), 1'b1, 1'b1, 2'd3};
  endfunction

  function automatic string pname(input logic [1:0] p);
    case (p)
      2'd0:    return "idle";
      2'd1:    return "show";
      2'd2:    return "invert";
      default: return "rotate";
    endcase
  endfunction

  // Advance one clock: update the model at the rising edge, queue the
  // prediction, return on the falling edge so the caller can drive inputs.
  task automatic step();
    bit entry;
    @(posedge clk);
    cyc++;
    entry = 1'b0;
    if (!rst_n) begin
      m_active = 1'b0;
      m_pend   = 0;
    end else begin
      if (m_pend > 0) begin
        m_pend--;
        entry = (m_pend == 0);
      end
      if (entry) begin
        m_active = 1'b1;
        m_k      = 0;
        m_pat    = m_sw;
      end else if (m_active) begin
        m_k++;
`ifndef SWSEQ_LOOP_EN
        if (m_k >= SEQ_LEN) m_active = 1'b0;
`endif
      end
    end
    exp_q.push_back(model_out());
    @(negedge clk);
  endtask

  task automatic press(input logic [7:0] v, input int low);
    sw     = v;
    key_n  = 1'b0;
    m_sw   = v;
    m_pend = ENTRY_LAT;
    repeat (low) step();
    key_n = 1'b1;
  endtask

  task automatic wait_k(input int target);
    int n;
    n = 0;
    while (!(m_pend == 0 && m_active && m_k == target) && n < 200) begin
      step();
      n++;
    end
    if (!(m_pend == 0 && m_active && m_k == target)) begin
      total++;
      bad++;
      $display("FAIL wait_k target=%0d not reached within %0d cycles", target, n);
    end
  endtask

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  // Monitor: one scoreboard comparison per cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      total++;
      if (a_out !== mon_e.a || b_out !== mon_e.b || busy !== mon_e.busy || phase !== mon_e.ph) begin
        bad++;
        $display("FAIL out_%s cyc=%0d got a=%h b=%b busy=%b ph=%0d want a=%h b=%b busy=%b ph=%0d",
                 pname(mon_e.ph), cyc, a_out, b_out, busy, phase,
                 mon_e.a, mon_e.b, mon_e.busy, mon_e.ph);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (3) step();
    #1;
    chk("rst_a_out", int'(a_out), 0);
    chk("rst_b_out", int'(b_out), 1);
    chk("rst_busy",  int'(busy),  0);
    chk("rst_phase", int'(phase), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) step();

    // Bounce: toggle every cycle, then stay high -> nothing happens
    for (int i = 0; i < 10; i++) begin
      key_n = ~key_n;
      step();
    end
    key_n = 1'b1;
    repeat (20) step();

    // Clean press held 7 cycles, full sequence with A5 (twice round if looping)
    press(8'hA5, 7);
    repeat (2 * SEQ_LEN + 20) step();

    // Restart during INVERT with 0F, then press colliding with end of SHOW
    press(8'h5C, DB_CYCLES + 1);
    wait_k(3);
    press(8'h0F, DB_CYCLES + 1);
    wait_k(1);
    press(8'h3C, DB_CYCLES + 1);
    repeat (SEQ_LEN + 10) step();

    // Randomized presses at random times
    for (int i = 0; i < 8; i++) begin
      press(8'($urandom), DB_CYCLES + 1 + int'($urandom_range(0, 3)));
      repeat (int'($urandom_range(10, 60))) step();
    end

    // Reset in the middle of ROTATE
    press(8'h81, DB_CYCLES + 1);
    wait_k(2 * SHOW_LEN + 6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_a_out", int'(a_out), 0);
    chk("midrst_b_out", int'(b_out), 1);
    chk("midrst_busy",  int'(busy),  0);
    chk("midrst_phase", int'(phase), 0);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (60) step();

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
